if_id_skid_stage: RTL and testbench

- Parametrised successor to the fixed IF/ID latch. It carries PC and instruction from fetch to decode using a valid/ready handshake.
- A 2-entry skid buffer keeps full throughput under back-pressure. Synchronous flush squashes wrong-path instructions.
- Sits between the instruction memory/PC adder path and the Control/Register File decode stage.
- When empty, it presents a NOP instruction so decode never sees stale data.

---
 rtl/if_id_skid_stage.sv | 107 ++++++++++
 tb/tb_if_id_skid_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a 2-entry skid buffer, synchronous flush
// and NOP presentation when empty. Optional stall/flush perf counters under IF_ID_PERF_CNT_EN.
module if_id_skid_stage #(
   parameter int                   INSTR_W   = 32,
   parameter int                   PC_W      = 32,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h0000_0000,
   parameter int                   PERF_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
`ifdef IF_ID_PERF_CNT_EN
   output logic [INSTR_W-1:0] out_instr,
   output logic [PERF_W-1:0]  stall_cnt,
   output logic [PERF_W-1:0]  flush_cnt
`else
   output logic [INSTR_W-1:0] out_instr
`endif
);

   // Handshake: a transfer happens on a rising clk edge when valid and ready are both high.
   // Producers hold valid and payload until the transfer; in_ready comes straight from a flop.
   logic               r_out_valid;
   logic [PC_W-1:0]    r_out_pc;
   logic [INSTR_W-1:0] r_out_instr;
   logic               r_skid_valid;
   logic [PC_W-1:0]    r_skid_pc;
   logic [INSTR_W-1:0] r_skid_instr;

   logic w_in_fire;
   logic w_main_free;

   assign in_ready    = ~r_skid_valid;
   assign w_in_fire   = in_valid & ~r_skid_valid;
   assign w_main_free = ~r_out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_out_valid  <= 1'b0;
         r_out_pc     <= '0;
         r_out_instr  <= NOP_INSTR;
         r_skid_valid <= 1'b0;
         if (rst) begin
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
         end
      end else if (w_main_free) begin
         if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_pc     <= r_skid_pc;
            r_out_instr  <= r_skid_instr;
            r_skid_valid <= 1'b0;
         end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= in_pc;
            r_out_instr <= in_instr;
         end else begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_instr <= NOP_INSTR;
         end
      end else if (w_in_fire) begin
         // Main is stalled by decode: park the new entry in the skid slot.
         r_skid_valid <= 1'b1;
         r_skid_pc    <= in_pc;
         r_skid_instr <= in_instr;
      end
   end

   assign out_valid = r_out_valid;
   assign out_pc    = r_out_pc;
   assign out_instr = r_out_instr;

`ifdef IF_ID_PERF_CNT_EN
   logic [PERF_W-1:0] r_stall_cnt;
   logic [PERF_W-1:0] r_flush_cnt;
   logic              w_stall_evt;
   logic              w_flush_evt;

   assign w_stall_evt = r_out_valid & ~out_ready & ~flush;
   assign w_flush_evt = flush & (r_out_valid | r_skid_valid | w_in_fire);

   // Both counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != {PERF_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush_evt && (r_flush_cnt != {PERF_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: directed scenario tasks plus a FIFO scoreboard
// fed by accepted inputs and drained by decode-side transfers.
module tb_if_id_skid_stage;
   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;
   localparam int PERF_W  = 4;
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;
`ifdef IF_ID_PERF_CNT_EN
   logic [PERF_W-1:0]  stall_cnt;
   logic [PERF_W-1:0]  flush_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [PC_W+INSTR_W-1:0] exp_q[$];

   if_id_skid_stage #(
      .INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP), .PERF_W(PERF_W)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
`ifdef IF_ID_PERF_CNT_EN
      .out_instr(out_instr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
      .out_instr(out_instr)
`endif
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: inputs sampled mid-cycle, before the edge that acts on them.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL scoreboard_unexpected: got pc=%h instr=%h, required no output", out_pc, out_instr);
            end else begin
               logic [PC_W+INSTR_W-1:0] e;
               e = exp_q.pop_front();
               if ({out_pc, out_instr} !== e) begin
                  errors = errors + 1;
                  $display("FAIL scoreboard_order: got pc=%h instr=%h, required pc=%h instr=%h",
                           out_pc, out_instr, e[PC_W+INSTR_W-1:INSTR_W], e[INSTR_W-1:0]);
               end
            end
         end
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back({in_pc, in_instr});
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic v, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
      in_valid = v;
      in_pc    = pc;
      in_instr = ins;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive_in(1'b1, 32'h0, 32'h2008_0005);
      tick();
      tick();
      rst = 1'b0;
      drive_in(1'b0, 32'h0, 32'h0);
      checks = checks + 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      if (out_instr !== NOP) begin errors++; $display("FAIL reset_out_instr: got %h, required %h", out_instr, NOP); end
      if (out_pc !== '0) begin errors++; $display("FAIL reset_out_pc: got %h, required 0", out_pc); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
   endtask

   task automatic test_streaming();
      logic [PC_W-1:0]    pcs[3];
      logic [INSTR_W-1:0] ins[3];
      pcs = '{32'h00, 32'h04, 32'h08};
      ins = '{32'h2008_0005, 32'h2009_000A, 32'h8D0A_0000};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_in(1'b1, pcs[i], ins[i]);
         tick();
         checks = checks + 1;
         if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== ins[i]) begin
            errors++;
            $display("FAIL stream_%0d: got v=%b pc=%h instr=%h, required v=1 pc=%h instr=%h",
                     i, out_valid, out_pc, out_instr, pcs[i], ins[i]);
         end
      end
      drive_in(1'b0, 32'h0, 32'h0);
      tick();
      checks = checks + 1;
      if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== '0) begin
         errors++;
         $display("FAIL stream_drain: got v=%b pc=%h instr=%h, required v=0 pc=0 instr=%h",
                  out_valid, out_pc, out_instr, NOP);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive_in(1'b1, 32'h00, 32'hA000_0000);
      tick();
      drive_in(1'b1, 32'h04, 32'hA000_0004);
      tick();
      checks = checks + 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready: got %b, required 0", in_ready); end
      if (out_pc !== 32'h00 || out_valid !== 1'b1) begin
         errors++; $display("FAIL skid_main_hold: got v=%b pc=%h, required v=1 pc=00", out_valid, out_pc);
      end
      drive_in(1'b1, 32'h08, 32'hA000_0008);
      tick();
      checks = checks + 1;
      if (out_pc !== 32'h00 || out_instr !== 32'hA000_0000 || in_ready !== 1'b0) begin
         errors++; $display("FAIL skid_stable: got pc=%h instr=%h rdy=%b, required pc=00 instr=a0000000 rdy=0",
                            out_pc, out_instr, in_ready);
      end
      out_ready = 1'b1;
      tick();
      checks = checks + 1;
      if (out_valid !== 1'b1 || out_pc !== 32'h04 || in_ready !== 1'b1) begin
         errors++; $display("FAIL skid_pop: got v=%b pc=%h rdy=%b, required v=1 pc=04 rdy=1", out_valid, out_pc, in_ready);
      end
      tick();
      drive_in(1'b0, 32'h0, 32'h0);
      checks = checks + 1;
      if (out_valid !== 1'b1 || out_pc !== 32'h08 || out_instr !== 32'hA000_0008) begin
         errors++; $display("FAIL skid_third: got v=%b pc=%h instr=%h, required v=1 pc=08 instr=a0000008",
                            out_valid, out_pc, out_instr);
      end
      tick();
      checks = checks + 1;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL skid_empty: got v=%b pending=%0d, required v=0 pending=0", out_valid, exp_q.size());
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive_in(1'b1, 32'h10, 32'hB000_0010);
      tick();
      drive_in(1'b1, 32'h14, 32'hB000_0014);
      tick();
      drive_in(1'b1, 32'h18, 32'hB000_0018);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive_in(1'b0, 32'h0, 32'h0);
      checks = checks + 1;
      if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== '0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_full: got v=%b pc=%h instr=%h rdy=%b, required v=0 pc=0 instr=%h rdy=1",
                            out_valid, out_pc, out_instr, in_ready, NOP);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks = checks + 1;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_leak_%0d: got v=%b pc=%h, required v=0", i, out_valid, out_pc);
         end
      end
      // Flush of an empty stage while fetch fires: the entry is accepted and discarded.
      drive_in(1'b1, 32'h1C, 32'hB000_001C);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive_in(1'b0, 32'h0, 32'h0);
      checks = checks + 1;
      if (out_valid !== 1'b0 || out_instr !== NOP) begin
         errors++; $display("FAIL flush_infire: got v=%b instr=%h, required v=0 instr=%h", out_valid, out_instr, NOP);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive_in(1'b1, 32'h20, 32'hC000_0020);
      tick();
      drive_in(1'b1, 32'h24, 32'hC000_0024);
      tick();
      rst = 1'b1;
      flush = 1'b1;
      tick();
      rst = 1'b0;
      flush = 1'b0;
      drive_in(1'b0, 32'h0, 32'h0);
      checks = checks + 1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== '0 || out_instr !== NOP) begin
         errors++; $display("FAIL reset_mid: got v=%b rdy=%b pc=%h instr=%h, required v=0 rdy=1 pc=0 instr=%h",
                            out_valid, in_ready, out_pc, out_instr, NOP);
      end
`ifdef IF_ID_PERF_CNT_EN
      checks = checks + 1;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         errors++; $display("FAIL reset_mid_cnt: got stall=%0d flush=%0d, required 0 0", stall_cnt, flush_cnt);
      end
`endif
   endtask

`ifdef IF_ID_PERF_CNT_EN
   task automatic test_perf();
      int stalls;
      out_ready = 1'b0;
      drive_in(1'b1, 32'h30, 32'hD000_0030);
      tick();
      drive_in(1'b0, 32'h0, 32'h0);
      stalls = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         stalls++;
         if (i == 4) begin
            checks = checks + 1;
            if (stall_cnt !== 4'd5) begin errors++; $display("FAIL perf_stall_mid: got %0d, required 5", stall_cnt); end
         end
      end
      checks = checks + 1;
      if (stall_cnt !== ((stalls > 15) ? 4'd15 : 4'(stalls))) begin
         errors++; $display("FAIL perf_stall_sat: got %0d, required 15", stall_cnt);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks = checks + 1;
      if (flush_cnt !== 4'd1 || stall_cnt !== 4'd15) begin
         errors++; $display("FAIL perf_flush: got flush=%0d stall=%0d, required flush=1 stall=15", flush_cnt, stall_cnt);
      end
      // A flush of an empty stage with no fetch is not counted.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks = checks + 1;
      if (flush_cnt !== 4'd1) begin errors++; $display("FAIL perf_flush_idle: got %0d, required 1", flush_cnt); end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         if (!(in_valid && !in_ready))
            drive_in(1'($urandom_range(0, 1)), PC_W'($urandom), INSTR_W'($urandom));
         out_ready = 1'($urandom_range(0, 3) != 0);
         tick();
         checks = checks + 1;
         if (out_valid === 1'b0 && (out_instr !== NOP || out_pc !== '0)) begin
            errors++; $display("FAIL random_nop: got pc=%h instr=%h while empty, required pc=0 instr=%h", out_pc, out_instr, NOP);
         end
      end
      drive_in(1'b0, 32'h0, 32'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks = checks + 1;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL random_drain: got pending=%0d v=%b, required pending=0 v=0", exp_q.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_to_back();
      test_flush();
      test_reset_mid();
`ifdef IF_ID_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
